reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side master for the 32x32 register file's single write port: produces write_reg / target_reg / write_rd_data each cycle.
- Merges two result sources:
  - the single-cycle ALU/load path (primary);
  - a long-latency mul/div unit (secondary), whose results are buffered in a small FIFO.
- Keeps a pending-register scoreboard and raises a hazard to the decode stage for operands whose value is still in flight.

Parameters:
- XLEN, 32, data width
- RA_W, 5, register address width
- FIFO_DEPTH, 2, secondary result buffer entries (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous active-high reset
- wb_valid  in  1  primary result present
- wb_rd  in  RA_W  primary destination register
- wb_data  in  XLEN  primary result
- wb_ready  out  1  primary result consumed this cycle
- md_issue  in  1  mul/div op issued this cycle
- md_issue_rd  in  RA_W  its destination register
- md_valid  in  1  mul/div result available
- md_rd  in  RA_W  its destination register
- md_data  in  XLEN  its result
- md_ready  out  1  result accepted into FIFO (md_valid && md_ready = transfer)
- rs1, rs2, rd_dec  in  RA_W  registers of the instruction in decode
- hazard  out  1  decode must stall
- write_reg  out  1  register file write enable
- target_reg  out  RA_W  register file write address
- write_rd_data  out  XLEN  register file write data

Behaviour:
- Reset (rst high, asynchronous):
  - FIFO empty (pointers and count 0); pending vector all 0.
  - While rst is high, all outputs are forced to 0: write_reg, target_reg, write_rd_data, wb_ready, md_ready, hazard.
- FIFO:
  - Push when md_valid && md_ready; md_ready = (count < FIFO_DEPTH), registered state only.
  - Pop when the head entry is selected for the write port.
  - Push and pop in the same cycle: count unchanged, both pointers advance, wrap modulo FIFO_DEPTH.
  - An md result with md_rd == 0 is accepted and then popped as a no-op: write_reg = 0, one port slot consumed.
- Write-port arbitration (combinational from current state and inputs):
  - FIFO full (count == FIFO_DEPTH): head wins and wb_ready = 0; the primary stage holds wb_* unchanged.
  - Otherwise, if wb_valid: primary wins and wb_ready = 1.
  - Otherwise, if FIFO not empty: head wins.
  - Otherwise: idle, write_reg = 0.
- Write-port outputs:
  - write_reg = winner valid && winner rd != 0.
  - target_reg / write_rd_data = winner fields.
  - Idle: all three are 0.
- Latency:
  - Primary: 0 cycles (written at the next posedge).
  - Secondary: at least 1 cycle after the push (FIFO is not bypassed).
- Scoreboard (pending[31:0], pending[0] hard-wired 0):
  - Set bit md_issue_rd on md_issue.
  - Clear bit head.rd on FIFO pop.
  - Set and clear of the same bit in the same cycle: set wins.
- Hazard:
  - hazard = pending[rs1] | pending[rs2] | pending[rd_dec] (RAW plus WAW).
  - Issuing to an already-pending rd is therefore prevented upstream; if it occurs anyway, the bit stays set until the next pop of that rd.
- Ordering: the FIFO preserves mul/div completion order.

Decomposition:
- Shared package: XLEN, RA_W, REG_X0 = 0, and a struct {rd, data} for a writeback entry.
- Natural sub-module: wb_fifo (parameterised synchronous FIFO with count, full and empty flags), reusable elsewhere in the pipeline.
- Scoreboard and arbiter stay inline in reg_writeback.

Test Plan:
- Reset then idle: assert rst mid-cycle with wb_valid = 1 → write_reg = 0 and md_ready = 0 immediately; after release, FIFO count 0 and hazard = 0 for any rs1/rs2.
- Primary only: wb_valid = 1, wb_rd = 5, wb_data = 0x1234 → same cycle write_reg = 1, target_reg = 5, data 0x1234, wb_ready = 1; with wb_rd = 0 → write_reg = 0, wb_ready = 1.
- Scoreboard: md_issue rd = 7; decode rs1 = 7 → hazard = 1. md_valid rd = 7, data 0xDEAD with wb_valid = 0 → pushed, written next cycle, hazard drops the cycle after the pop.
- Contention: md results for rd 3 then rd 4 pushed while wb_valid is held high → FIFO reaches 2, md_ready = 0. Next cycle wb_ready = 0 and rd 3 is written, then primary resumes; rd 4 written when wb_valid drops or the FIFO is full again.
- Simultaneous set and clear: pop of rd 9 in the same cycle as md_issue rd 9 → pending[9] remains 1.
- Wrap-around: stream 10 md results with alternating wb_valid → all written in order with correct data, and pointers wrap without loss.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register-file write side.
//   XLEN     : register data width
//   RA_W     : register address width
//   NUM_REGS : number of architectural registers
//   REG_X0   : hard-wired zero register
//   wb_entry_t : one pending writeback (destination + data)
package reg_writeback_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RA_W     = 5;
  localparam int unsigned NUM_REGS = 1 << RA_W;

  localparam logic [RA_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_fifo.sv
// Parameterised synchronous FIFO with occupancy count and full/empty flags.
// Head entry is presented combinationally on rdata. Depth must be a power of two
// so the pointers wrap naturally.
//   clk, rst     : clock, asynchronous active-high reset
//   push, wdata  : enqueue (ignored while full)
//   pop, rdata   : dequeue (ignored while empty), head entry
//   count        : current occupancy
//   full, empty  : occupancy flags
module reg_writeback_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset; valid entries are tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port master. Merges the single-cycle primary result path
// with buffered mul/div results and tracks registers whose values are in flight.
//   clk, rst                      : clock, asynchronous active-high reset
//   wb_valid/wb_rd/wb_data        : primary result, wb_ready when consumed
//   md_issue/md_issue_rd          : mul/div issue, marks rd pending
//   md_valid/md_rd/md_data        : mul/div result, md_ready when accepted
//   rs1/rs2/rd_dec, hazard        : decode operands, stall request
//   write_reg/target_reg/write_rd_data : register-file write port
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_ready,
  input  logic            md_issue,
  input  logic [RA_W-1:0] md_issue_rd,
  input  logic            md_valid,
  input  logic [RA_W-1:0] md_rd,
  input  logic [XLEN-1:0] md_data,
  output logic            md_ready,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  input  logic [RA_W-1:0] rd_dec,
  output logic            hazard,
  output logic            write_reg,
  output logic [RA_W-1:0] target_reg,
  output logic [XLEN-1:0] write_rd_data
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  wb_entry_t           push_entry, head_entry;
  logic [CntW-1:0]     fifo_count;
  logic                fifo_full, fifo_empty;
  logic                fifo_push, fifo_pop;
  logic                sel_wb, sel_head;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  assign push_entry = '{rd: md_rd, data: md_data};
  assign md_ready   = !rst && (fifo_count < CntW'(FIFO_DEPTH));
  assign fifo_push  = md_valid && md_ready;

  reg_writeback_fifo #(
    .Width($bits(wb_entry_t)),
    .Depth(FIFO_DEPTH)
  ) u_md_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A full buffer takes priority so the mul/div unit can never be starved.
  always_comb begin
    sel_wb   = 1'b0;
    sel_head = 1'b0;
    if (!fifo_full && wb_valid) sel_wb = 1'b1;
    else if (!fifo_empty)       sel_head = 1'b1;
  end

  assign fifo_pop = sel_head && !rst;
  assign wb_ready = sel_wb && !rst;

  always_comb begin
    write_reg     = 1'b0;
    target_reg    = '0;
    write_rd_data = '0;
    if (!rst) begin
      if (sel_wb) begin
        write_reg     = (wb_rd != REG_X0);
        target_reg    = wb_rd;
        write_rd_data = wb_data;
      end else if (sel_head) begin
        // rd == x0 still consumes the slot, just without a write.
        write_reg     = (head_entry.rd != REG_X0);
        target_reg    = head_entry.rd;
        write_rd_data = head_entry.data;
      end
    end
  end

  // Clear before set so a same-cycle issue to the popped rd stays pending.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop) pending_d[head_entry.rd] = 1'b0;
    if (md_issue) pending_d[md_issue_rd]   = 1'b1;
    pending_d[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign hazard = !rst && (pending_q[rs1] || pending_q[rs2] || pending_q[rd_dec]);

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid, md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic [4:0]  rs1, rs2, rd_dec;
  logic        hazard;
  logic        write_reg;
  logic [4:0]  target_reg;
  logic [31:0] write_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_writeback #(.FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_ready      (wb_ready),
    .md_issue      (md_issue),
    .md_issue_rd   (md_issue_rd),
    .md_valid      (md_valid),
    .md_rd         (md_rd),
    .md_data       (md_data),
    .md_ready      (md_ready),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd_dec        (rd_dec),
    .hazard        (hazard),
    .write_reg     (write_reg),
    .target_reg    (target_reg),
    .write_rd_data (write_rd_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic we, input logic [4:0] rd,
                             input logic [31:0] data);
    check({tag, "_we"}, 64'(write_reg), 64'(we));
    check({tag, "_rd"}, 64'(target_reg), 64'(rd));
    check({tag, "_data"}, 64'(write_rd_data), 64'(data));
  endtask

  int idx_push, idx_wr, cyc;

  initial begin
    rst = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    md_issue = 1'b0; md_issue_rd = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
    rs1 = '0; rs2 = '0; rd_dec = '0;

    // Reset state: outputs forced low even with a primary result present
    #3;
    check_write("rst", 1'b0, 5'd0, 32'h0);
    check("rst_md_ready", 64'(md_ready), 64'd0);
    check("rst_wb_ready", 64'(wb_ready), 64'd0);
    check("rst_hazard", 64'(hazard), 64'd0);
    @(negedge clk);
    rst = 1'b0; wb_valid = 1'b0;
    rs1 = 5'd7; rs2 = 5'd31; rd_dec = 5'd1;
    #1;
    check("idle_md_ready", 64'(md_ready), 64'd1);
    check("idle_hazard", 64'(hazard), 64'd0);
    check("idle_we", 64'(write_reg), 64'd0);
    rs2 = '0; rd_dec = '0;

    // Mid-cycle asynchronous reset with pending state
    md_issue = 1'b1; md_issue_rd = 5'd7;
    tick();
    md_issue = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    check("pre_rst_hazard", 64'(hazard), 64'd1);
    check("pre_rst_we", 64'(write_reg), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_we", 64'(write_reg), 64'd0);
    check("async_rst_md_ready", 64'(md_ready), 64'd0);
    check("async_rst_hazard", 64'(hazard), 64'd0);
    @(negedge clk);
    rst = 1'b0; wb_valid = 1'b0;
    #1;
    check("post_rst_hazard", 64'(hazard), 64'd0);
    rs1 = '0;

    // Primary path, zero latency
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    #1;
    check_write("prim", 1'b1, 5'd5, 32'h1234);
    check("prim_ready", 64'(wb_ready), 64'd1);
    wb_rd = 5'd0;
    #1;
    check("prim_x0_we", 64'(write_reg), 64'd0);
    check("prim_x0_ready", 64'(wb_ready), 64'd1);
    wb_valid = 1'b0;

    // Scoreboard set, RAW/WAW hazard, clear on pop
    tick();
    md_issue = 1'b1; md_issue_rd = 5'd7; rs1 = 5'd7;
    #1;
    check("sb_before_edge", 64'(hazard), 64'd0);
    tick();
    md_issue = 1'b0;
    #1;
    check("sb_rs1", 64'(hazard), 64'd1);
    rs1 = '0; rs2 = 5'd7;
    #1;
    check("sb_rs2", 64'(hazard), 64'd1);
    rs2 = '0; rd_dec = 5'd7;
    #1;
    check("sb_rd_dec", 64'(hazard), 64'd1);
    rd_dec = '0; rs1 = 5'd7;
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'hDEAD;
    #1;
    check("sb_md_ready", 64'(md_ready), 64'd1);
    check("sb_no_bypass", 64'(write_reg), 64'd0);
    tick();
    md_valid = 1'b0;
    #1;
    check_write("sb_pop", 1'b1, 5'd7, 32'hDEAD);
    check("sb_hazard_during_pop", 64'(hazard), 64'd1);
    tick();
    #1;
    check("sb_hazard_cleared", 64'(hazard), 64'd0);
    check("sb_idle_we", 64'(write_reg), 64'd0);
    rs1 = '0;

    // Contention: FIFO fills while primary keeps the port busy
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hA0;
    md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h33;
    #1;
    check_write("ct0", 1'b1, 5'd10, 32'hA0);
    tick();
    wb_rd = 5'd11; wb_data = 32'hA1;
    md_rd = 5'd4; md_data = 32'h44;
    #1;
    check_write("ct1", 1'b1, 5'd11, 32'hA1);
    check("ct1_md_ready", 64'(md_ready), 64'd1);
    tick();
    md_valid = 1'b0; wb_rd = 5'd12; wb_data = 32'hA2;
    #1;
    check("ct_full_md_ready", 64'(md_ready), 64'd0);
    check("ct_full_wb_ready", 64'(wb_ready), 64'd0);
    check_write("ct_full", 1'b1, 5'd3, 32'h33);
    tick();
    #1;
    check("ct_resume_ready", 64'(wb_ready), 64'd1);
    check_write("ct_resume", 1'b1, 5'd12, 32'hA2);
    tick();
    wb_valid = 1'b0;
    #1;
    check_write("ct_drain", 1'b1, 5'd4, 32'h44);
    tick();
    #1;
    check("ct_empty_we", 64'(write_reg), 64'd0);

    // Same-cycle set and clear of rd 9: set wins
    md_issue = 1'b1; md_issue_rd = 5'd9;
    tick();
    md_issue = 1'b0;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
    tick();
    md_valid = 1'b0;
    md_issue = 1'b1; md_issue_rd = 5'd9;
    #1;
    check_write("sc_pop", 1'b1, 5'd9, 32'h99);
    tick();
    md_issue = 1'b0; rs1 = 5'd9;
    #1;
    check("sc_set_wins", 64'(hazard), 64'd1);
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h98;
    tick();
    md_valid = 1'b0;
    tick();
    #1;
    check("sc_cleared", 64'(hazard), 64'd0);
    rs1 = '0;

    // md result to x0: accepted, popped without a write
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h55;
    tick();
    md_valid = 1'b0;
    #1;
    check("x0_pop_we", 64'(write_reg), 64'd0);
    tick();
    #1;
    check("x0_md_ready", 64'(md_ready), 64'd1);

    // Wrap-around: 10 md results, alternating primary traffic
    idx_push = 0; idx_wr = 0; cyc = 0;
    while (idx_wr < 10 && cyc < 60) begin
      wb_valid = cyc[0]; wb_rd = 5'd20; wb_data = 32'(cyc);
      md_valid = (idx_push < 10);
      md_rd = 5'(21 + idx_push); md_data = 32'hC000 + 32'(idx_push);
      #1;
      if (wb_ready) begin
        check_write("wrap_prim", 1'b1, 5'd20, 32'(cyc));
      end else if (write_reg) begin
        check("wrap_rd", 64'(target_reg), 64'(21 + idx_wr));
        check("wrap_data", 64'(write_rd_data), 64'(32'hC000 + 32'(idx_wr)));
        idx_wr++;
      end
      if (md_valid && md_ready) idx_push++;
      tick();
      cyc++;
    end
    wb_valid = 1'b0; md_valid = 1'b0;
    check("wrap_count", 64'(idx_wr), 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
